// File: rtl/weight_bank_reader.sv
// weight_bank_reader: walks a contiguous range of weight-bank rows and reads each
// row with one READ command. It unpacks each row into three signed weights,
// least-significant field first, and streams them to the MAC datapath.
//
// Handshake: weight_out/weight_last are meaningful while weight_valid=1. A weight
// is consumed at a rising edge where weight_valid && weight_ready. While valid is
// high and ready is low, valid, data and last hold their values.
`timescale 1ns/1ps
module weight_bank_reader #(
  parameter int Amba_Addr_Depth = 12,
  parameter int WeightPrecision = 5,
  parameter int WeightRowWidth  = 15
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic        [Amba_Addr_Depth:0]   base_addr,
  input  logic        [Amba_Addr_Depth:0]   num_rows,
  output logic                              busy,
  output logic                              done,
  output logic        [1:0]                 bank_control,
  output logic        [Amba_Addr_Depth:0]   bank_address,
  input  logic        [WeightRowWidth-1:0]  bank_ReadData,
  output logic signed [WeightPrecision-1:0] weight_out,
  output logic                              weight_valid,
  input  logic                              weight_ready,
  output logic                              weight_last,
  output logic        [2:0]                 state_dbg
);

  localparam int AW = Amba_Addr_Depth;
  localparam int W  = WeightPrecision;

  localparam logic [1:0]    CMD_IDLE  = 2'b00;
  localparam logic [1:0]    CMD_READ  = 2'b10;
  localparam logic [1:0]    LAST_SLOT = 2'd2;
  localparam logic [AW:0]   ROW_ZERO  = '0;
  localparam logic [AW:0]   ROW_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LOW_ONE   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [AW:0]           addr_q, addr_d;
  logic [AW:0]           rows_left_q, rows_left_d;
  logic [1:0]            slot_q, slot_d;
  logic [WeightRowWidth-1:0] row_q, row_d;

  logic                  busy_d, done_d, weight_valid_d, weight_last_d;
  logic [1:0]            bank_control_d;
  logic [AW:0]           bank_address_d;
  logic [W-1:0]          field;
  logic signed [W-1:0]   weight_out_d;
  logic                  handshake;

  assign handshake = weight_valid && weight_ready;
  assign state_dbg = state_q;

  // Next-state and datapath update: sequencing of rows and slots.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rows_left_d = rows_left_q;
    slot_d      = slot_q;
    row_d       = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          rows_left_d = num_rows;
          state_d     = (num_rows == ROW_ZERO) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  state_d = S_CAPT;
      S_CAPT: begin
        row_d   = bank_ReadData;
        slot_d  = 2'd0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (handshake) begin
          if (slot_q != LAST_SLOT) begin
            slot_d = slot_q + 2'd1;
          end else begin
            rows_left_d = rows_left_q - ROW_ONE;
            if (rows_left_q == ROW_ONE) begin
              state_d = S_DONE;
            end else begin
              // Low bits wrap at the bank depth; the top bit rides along unchanged.
              addr_d  = {addr_q[AW], addr_q[AW-1:0] + LOW_ONE};
              state_d = S_REQ;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that every output is a flop.
  always_comb begin
    busy_d         = (state_d == S_REQ) || (state_d == S_CAPT) || (state_d == S_EMIT);
    done_d         = (state_d == S_DONE);
    bank_control_d = (state_d == S_REQ) ? CMD_READ : CMD_IDLE;
    bank_address_d = (state_d == S_REQ) ? addr_d : bank_address;
    weight_valid_d = (state_d == S_EMIT);
    weight_last_d  = weight_valid_d && (slot_d == LAST_SLOT) && (rows_left_d == ROW_ONE);
    field          = '0;
    case (slot_d)
      2'd0:    field = row_d[W-1:0];
      2'd1:    field = row_d[2*W-1:W];
      default: field = row_d[3*W-1:2*W];
    endcase
    weight_out_d = weight_valid_d ? field : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      slot_q      <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rows_left_q <= rows_left_d;
      slot_q      <= slot_d;
      row_q       <= row_d;
    end
  end

  // Registered outputs; reset clears them without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      bank_control <= CMD_IDLE;
      bank_address <= '0;
      weight_out   <= '0;
      weight_valid <= 1'b0;
      weight_last  <= 1'b0;
    end else begin
      busy         <= busy_d;
      done         <= done_d;
      bank_control <= bank_control_d;
      bank_address <= bank_address_d;
      weight_out   <= weight_out_d;
      weight_valid <= weight_valid_d;
      weight_last  <= weight_last_d;
    end
  end

endmodule
